io_switch_ctrl: RTL and testbench
=================================

Name: io_switch_ctrl

Overview:
- Failover controller that drives `ctr_io` for the input/output switch fabric between redundant CPU A and CPU B.
- Monitors a heartbeat toggle from each CPU, declares each CPU alive or dead by timeout, and selects the active CPU. Automatic failover and a manual force request are both supported.
- Every switchover passes through a guard interval so downstream muxes can hold safe values. A minimum dwell time prevents ping-pong.

Parameters:
- TIMEOUT, 1000: cycles without a heartbeat edge before a CPU is declared dead.
- GUARD, 16: cycles `guard` is held high before `ctr_io` changes.
- DWELL, 4096: minimum cycles on one CPU before an automatic failover is allowed.
- CNT_W, 16: width of the timeout and dwell counters. Must hold max(TIMEOUT, DWELL, GUARD).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- hb_a  input  1  heartbeat from CPU A, asynchronous; any toggle counts as a beat
- hb_b  input  1  heartbeat from CPU B, asynchronous
- force_req  input  1  one-cycle pulse requesting a manual switch
- force_sel  input  1  manual target: 0 = A, 1 = B; sampled with force_req
- ctr_io  output  1  active CPU: 0 = A, 1 = B
- guard  output  1  high during the switchover guard interval
- alive_a  output  1  CPU A heartbeat status
- alive_b  output  1  CPU B heartbeat status
- switch_pulse  output  1  one-cycle pulse on the cycle `ctr_io` changes

Behaviour:
- Reset is asynchronous on `rst_n` low. Reset values: `ctr_io`=0, `guard`=0, `alive_a`=0, `alive_b`=0, `switch_pulse`=0, state ACT_A, all counters 0, synchronizer flops 0.
- Heartbeat path, per CPU:
  - Two-flop synchronizer, then a third register; beat = s2 ^ s3.
  - A pin toggle is seen as a beat 3 cycles later.
  - On a beat: timeout counter clears, alive goes to 1 on the next cycle.
  - Otherwise the counter increments and saturates. When it reaches TIMEOUT-1, alive goes to 0 on the next cycle.
- Dwell counter:
  - Clears on every switch and on reset, then increments and saturates at DWELL.
  - dwell_done = (count == DWELL).
- FSM states: ACT_A, GRD_TO_B, ACT_B, GRD_TO_A.
- ACT_A goes to GRD_TO_B when either holds:
  - (!alive_a && alive_b && dwell_done), or
  - (force_req && force_sel==1 && alive_b).
- ACT_B goes to GRD_TO_A symmetrically.
- Force requests ignore dwell but never switch to a dead CPU. A force to the CPU already active is ignored.
- Both CPUs dead: stay in the current state, `ctr_io` unchanged.
- GRD_x state:
  - `guard`=1 for exactly GUARD cycles; the guard counter counts 0..GUARD-1.
  - `ctr_io` holds its old value throughout the guard interval.
  - On the cycle after the last guard cycle: enter ACT_x, `guard`=0, `ctr_io` takes the new value, `switch_pulse`=1 for one cycle, dwell counter clears.
- All `force_req` pulses and alive changes during GRD are ignored. The guard interval always completes.
- Simultaneous auto and force conditions in the same cycle: the same transition is taken, once.
- Reset asserted mid-guard: immediate return to ACT_A with all outputs at reset values. No `switch_pulse` is issued.
- All outputs are registered.

Optional Feature:
- Macro: IO_SWITCH_CNT_EN.
- Defined: adds output `switch_cnt` [7:0], reset to 0. It increments on each `switch_pulse` and saturates at 8'hff.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use TIMEOUT=8, GUARD=4, DWELL=32.
- Reset, then toggle `hb_a` every 4 cycles and hold `hb_b` static. Expect `alive_a`=1 from 4 cycles after the first toggle, `alive_b` stays 0, `ctr_io` stays 0, and no `switch_pulse`.
- Both heartbeats running for 40 cycles, then stop `hb_a`. Expect `alive_a`=0 about 8 cycles after the last detected beat. Then `guard`=1 for 4 cycles, then `ctr_io`=1 with a single `switch_pulse`.
- Immediately after a switch to B, stop `hb_b` with `hb_a` running. Expect no switch back until the dwell counter reaches 32. After that, a guard of 4 cycles, then `ctr_io`=0.
- On ACT_A with both alive, pulse `force_req` with `force_sel`=1. Expect `guard`=1 on the next cycle for 4 cycles, then `ctr_io`=1. Pulse `force_req` with `force_sel`=1 again: ignored. Force toward a dead CPU: ignored.
- Stop both heartbeats. Expect both alive flags 0 and `ctr_io` unchanged indefinitely. Pulse `force_req` during a guard interval: no extra switch.
- Assert `rst_n` low in the 2nd guard cycle. Expect immediate `ctr_io`=0, `guard`=0, and `switch_cnt`=0 when IO_SWITCH_CNT_EN is defined. Separately, 300 forced switches give `switch_cnt`=8'hff.

Source files
------------

// File: rtl/io_switch_ctrl.sv
// Redundant-CPU I/O switch failover controller: heartbeat supervision, guarded switchover, dwell hold-off.
// Define IO_SWITCH_CNT_EN to add the saturating 8-bit switch_cnt output.
module io_switch_ctrl #(
  parameter int TIMEOUT = 1000,
  parameter int GUARD   = 16,
  parameter int DWELL   = 4096,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hb_a,
  input  logic       hb_b,
  input  logic       force_req,
  input  logic       force_sel,
  output logic       ctr_io,
  output logic       guard,
  output logic       alive_a,
  output logic       alive_b,
  output logic       switch_pulse
`ifdef IO_SWITCH_CNT_EN
  ,
  output logic [7:0] switch_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DW_MAX = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] GD_MAX = CNT_W'(GUARD - 1);

  typedef enum logic [1:0] {ACT_A, GRD_TO_B, ACT_B, GRD_TO_A} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]   to_a_q, to_a_d, to_b_q, to_b_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d, gcnt_q, gcnt_d;
  logic               alive_a_q, alive_a_d, alive_b_q, alive_b_d;
  logic               ctr_io_q, ctr_io_d, guard_q, guard_d, pulse_q, pulse_d;
  logic               beat_a, beat_b, dwell_done;
`ifdef IO_SWITCH_CNT_EN
  logic [7:0]         scnt_q, scnt_d;
`endif

  // Heartbeat supervision: bit0/bit1 synchronise, bit2 delays for toggle detection.
  always_comb begin
    sa_d      = {sa_q[1:0], hb_a};
    sb_d      = {sb_q[1:0], hb_b};
    beat_a    = sa_q[1] ^ sa_q[2];
    beat_b    = sb_q[1] ^ sb_q[2];
    to_a_d    = beat_a ? '0 : ((to_a_q == TO_MAX) ? to_a_q : to_a_q + ONE);
    to_b_d    = beat_b ? '0 : ((to_b_q == TO_MAX) ? to_b_q : to_b_q + ONE);
    alive_a_d = beat_a ? 1'b1 : ((to_a_q == TO_MAX) ? 1'b0 : alive_a_q);
    alive_b_d = beat_b ? 1'b1 : ((to_b_q == TO_MAX) ? 1'b0 : alive_b_q);
  end

  assign dwell_done = (dwell_q == DW_MAX);

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    guard_d  = 1'b0;
    ctr_io_d = ctr_io_q;
    pulse_d  = 1'b0;
    dwell_d  = dwell_done ? dwell_q : dwell_q + ONE;
    unique case (state_q)
      ACT_A: begin
        if ((!alive_a_q && alive_b_q && dwell_done) || (force_req && force_sel && alive_b_q)) begin
          state_d = GRD_TO_B;
          guard_d = 1'b1;
          gcnt_d  = '0;
        end
      end
      ACT_B: begin
        if ((!alive_b_q && alive_a_q && dwell_done) || (force_req && !force_sel && alive_a_q)) begin
          state_d = GRD_TO_A;
          guard_d = 1'b1;
          gcnt_d  = '0;
        end
      end
      GRD_TO_B: begin
        if (gcnt_q == GD_MAX) begin
          state_d  = ACT_B;
          ctr_io_d = 1'b1;
          pulse_d  = 1'b1;
          dwell_d  = '0;
        end else begin
          guard_d = 1'b1;
          gcnt_d  = gcnt_q + ONE;
        end
      end
      GRD_TO_A: begin
        if (gcnt_q == GD_MAX) begin
          state_d  = ACT_A;
          ctr_io_d = 1'b0;
          pulse_d  = 1'b1;
          dwell_d  = '0;
        end else begin
          guard_d = 1'b1;
          gcnt_d  = gcnt_q + ONE;
        end
      end
      default: state_d = ACT_A;
    endcase
  end

`ifdef IO_SWITCH_CNT_EN
  always_comb begin
    scnt_d = scnt_q;
    if (pulse_d && (scnt_q != 8'hff)) scnt_d = scnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACT_A;
      sa_q      <= '0;
      sb_q      <= '0;
      to_a_q    <= '0;
      to_b_q    <= '0;
      dwell_q   <= '0;
      gcnt_q    <= '0;
      alive_a_q <= 1'b0;
      alive_b_q <= 1'b0;
      ctr_io_q  <= 1'b0;
      guard_q   <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef IO_SWITCH_CNT_EN
      scnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      to_a_q    <= to_a_d;
      to_b_q    <= to_b_d;
      dwell_q   <= dwell_d;
      gcnt_q    <= gcnt_d;
      alive_a_q <= alive_a_d;
      alive_b_q <= alive_b_d;
      ctr_io_q  <= ctr_io_d;
      guard_q   <= guard_d;
      pulse_q   <= pulse_d;
`ifdef IO_SWITCH_CNT_EN
      scnt_q    <= scnt_d;
`endif
    end
  end

  assign ctr_io       = ctr_io_q;
  assign guard        = guard_q;
  assign alive_a      = alive_a_q;
  assign alive_b      = alive_b_q;
  assign switch_pulse = pulse_q;
`ifdef IO_SWITCH_CNT_EN
  assign switch_cnt   = scnt_q;
`endif

endmodule

// File: tb/tb_io_switch_ctrl.sv
// Bench for io_switch_ctrl: directed failover scenarios plus randomized heartbeats/forces vs a reference model.
module tb_io_switch_ctrl;
  localparam int TIMEOUT = 8;
  localparam int GUARD   = 4;
  localparam int DWELL   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hb_a = 1'b0, hb_b = 1'b0, force_req = 1'b0, force_sel = 1'b0;
  logic ctr_io, guard, alive_a, alive_b, switch_pulse;
`ifdef IO_SWITCH_CNT_EN
  logic [7:0] switch_cnt;
`endif

  int errors = 0;
  int checks = 0;

  io_switch_ctrl #(.TIMEOUT(TIMEOUT), .GUARD(GUARD), .DWELL(DWELL), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hb_a(hb_a), .hb_b(hb_b),
    .force_req(force_req), .force_sel(force_sel),
    .ctr_io(ctr_io), .guard(guard), .alive_a(alive_a), .alive_b(alive_b),
    .switch_pulse(switch_pulse)
`ifdef IO_SWITCH_CNT_EN
    , .switch_cnt(switch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an observed pin change keeps a CPU alive from 2 to TIMEOUT+1 edges later.
  int  e;
  int  chg_a[$], chg_b[$];
  bit  prev_a, prev_b;
  bit  m_act, m_target, m_alive_a, m_alive_b, m_pulse;
  int  m_guard_left, m_since, m_cnt;

  bit  run_a, run_b;
  int  per_a, per_b, cyc, pulses_seen, n, p0;

  task automatic model_reset();
    e = 0; chg_a.delete(); chg_b.delete(); prev_a = 0; prev_b = 0;
    m_act = 0; m_target = 0; m_alive_a = 0; m_alive_b = 0; m_pulse = 0;
    m_guard_left = 0; m_since = 0; m_cnt = 0;
  endtask

  function automatic bit recent(input int q[$], input int now);
    foreach (q[i]) if ((now - q[i] >= 2) && (now - q[i] <= TIMEOUT + 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit want, al_want, al_cur;
    e++;
    m_pulse = 0;
    if (m_guard_left > 0) begin
      m_guard_left--;
      if (m_guard_left == 0) begin
        m_act = m_target; m_pulse = 1; m_since = 0;
        if (m_cnt < 255) m_cnt++;
      end else m_since++;
    end else begin
      want    = !m_act;
      al_want = want ? m_alive_b : m_alive_a;
      al_cur  = m_act ? m_alive_b : m_alive_a;
      if ((!al_cur && al_want && m_since >= DWELL) || (force_req && (force_sel == want) && al_want)) begin
        m_guard_left = GUARD; m_target = want;
      end
      if (m_since < 1000000) m_since++;
    end
    if (hb_a != prev_a) chg_a.push_back(e);
    if (hb_b != prev_b) chg_b.push_back(e);
    prev_a = hb_a; prev_b = hb_b;
    while (chg_a.size() > 0 && e - chg_a[0] > TIMEOUT + 1) chg_a.delete(0);
    while (chg_b.size() > 0 && e - chg_b[0] > TIMEOUT + 1) chg_b.delete(0);
    m_alive_a = recent(chg_a, e);
    m_alive_b = recent(chg_b, e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ctr_io", {31'd0, ctr_io}, {31'd0, m_act});
    chk("guard", {31'd0, guard}, {31'd0, (m_guard_left > 0)});
    chk("alive_a", {31'd0, alive_a}, {31'd0, m_alive_a});
    chk("alive_b", {31'd0, alive_b}, {31'd0, m_alive_b});
    chk("switch_pulse", {31'd0, switch_pulse}, {31'd0, m_pulse});
`ifdef IO_SWITCH_CNT_EN
    chk("switch_cnt", {24'd0, switch_cnt}, m_cnt);
`endif
  endtask

  task automatic tick(input bit fr, input bit fs);
    force_req = fr;
    force_sel = fs;
    cyc++;
    if (run_a && ((per_a == 0) ? ($urandom_range(0, 2) == 0) : (cyc % per_a == 0))) hb_a = ~hb_a;
    if (run_b && ((per_b == 0) ? ($urandom_range(0, 2) == 0) : (cyc % per_b == 0))) hb_b = ~hb_b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (switch_pulse === 1'b1) pulses_seen++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    run_a = 0; run_b = 0; per_a = 4; per_b = 4; cyc = 0; pulses_seen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Only A beating
    run_a = 1;
    repeat (40) tick(0, 0);
    chk("s1_alive_a", alive_a, 1);
    chk("s1_alive_b", alive_b, 0);
    chk("s1_pulses", pulses_seen, 0);

    // Both beating, then A stops: automatic failover to B
    run_b = 1;
    repeat (40) tick(0, 0);
    run_a = 0;
    for (int i = 0; i < 60 && ctr_io !== 1'b1; i++) tick(0, 0);
    chk("s2_ctr_io", ctr_io, 1);
    chk("s2_pulses", pulses_seen, 1);

    // B stops right after switch: return to A only after dwell
    run_b = 0; run_a = 1;
    for (n = 0; n < 100 && ctr_io !== 1'b0; n++) tick(0, 0);
    chk("s3_ctr_io", ctr_io, 0);
    chk("s3_dwell_held", (n >= DWELL + GUARD), 1);

    // Forced switches
    run_b = 1;
    repeat (12) tick(0, 0);
    tick(1, 1);
    chk("s4_guard_next", guard, 1);
    repeat (6) tick(0, 0);
    chk("s4_forced", ctr_io, 1);
    p0 = pulses_seen;
    tick(1, 1);
    repeat (6) tick(0, 0);
    chk("s4_same_ignored", pulses_seen - p0, 0);
    run_a = 0;
    repeat (15) tick(0, 0);
    chk("s4_a_dead", alive_a, 0);
    tick(1, 0);
    repeat (6) tick(0, 0);
    chk("s4_dead_target", ctr_io, 1);

    // Both dead, then force during guard
    run_b = 0;
    repeat (30) tick(0, 0);
    chk("s5_both_dead", {alive_a, alive_b}, 2'b00);
    chk("s5_hold", ctr_io, 1);
    run_b = 1;
    repeat (12) tick(0, 0);
    run_a = 1;
    repeat (12) tick(0, 0);
    p0 = pulses_seen;
    tick(1, 0);
    tick(1, 1);
    tick(1, 1);
    repeat (5) tick(0, 0);
    chk("s5_ctr_io", ctr_io, 0);
    chk("s5_one_switch", pulses_seen - p0, 1);

    // Reset in second guard cycle of a B->A switch
    tick(1, 1);
    repeat (6) tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    chk("s6_in_guard", guard, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ctr_io", ctr_io, 0);
    chk("s6_rst_guard", guard, 0);
    chk("s6_rst_alive", {alive_a, alive_b}, 2'b00);
    chk("s6_rst_pulse", switch_pulse, 0);
`ifdef IO_SWITCH_CNT_EN
    chk("s6_rst_cnt", switch_cnt, 0);
`endif
    model_reset();
    force_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses_seen;
    repeat (20) tick(0, 0);
    chk("s6_no_pulse", pulses_seen - p0, 0);

    // Randomized heartbeats and force requests
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        run_a = ($urandom_range(0, 3) != 0);
        run_b = ($urandom_range(0, 3) != 0);
        per_a = $urandom_range(0, 6);
        per_b = $urandom_range(0, 6);
      end
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

`ifdef IO_SWITCH_CNT_EN
    run_a = 1; run_b = 1; per_a = 4; per_b = 4;
    repeat (12) tick(0, 0);
    for (int i = 0; i < 300; i++) begin
      tick(1, !ctr_io);
      repeat (GUARD) tick(0, 0);
    end
    chk("s8_cnt_sat", switch_cnt, 8'hff);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
